// File: rtl/fbw_stream_loader.sv
// Byte-stream to hub75 frame-buffer write bridge: pairs bytes into 16-bit pixels,
// fills and commits one row at a time, then requests a frame swap.
module fbw_stream_loader #(
   parameter int N_ROWS     = 64,
   parameter int N_COLS     = 64,
   parameter int BITDEPTH   = 16,
   localparam int LOG_N_ROWS = $clog2(N_ROWS),
   localparam int LOG_N_COLS = $clog2(N_COLS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [LOG_N_ROWS-1:0] fbw_row_addr,
   output logic                  fbw_row_store,
   input  logic                  fbw_row_rdy,
   output logic                  fbw_row_swap,
   output logic [BITDEPTH-1:0]   fbw_data,
   output logic [LOG_N_COLS-1:0] fbw_col_addr,
   output logic                  fbw_wren,
   output logic                  frame_swap,
   input  logic                  frame_rdy
);

   localparam logic [LOG_N_ROWS-1:0] ROW_LAST = LOG_N_ROWS'(N_ROWS - 1);
   localparam logic [LOG_N_COLS-1:0] COL_LAST = LOG_N_COLS'(N_COLS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STORE_WAIT,
      S_FRAME_SWAP,
      S_FRAME_WAIT
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_busy;
   logic                  r_phase;
   logic [7:0]            r_lo;
   logic [LOG_N_COLS-1:0] r_col;
   logic [LOG_N_ROWS-1:0] r_row;
   logic                  r_wren;
   logic [BITDEPTH-1:0]   r_data;
   logic [LOG_N_COLS-1:0] r_col_addr;
   logic                  r_store;
   logic [LOG_N_ROWS-1:0] r_row_addr;
   logic                  r_fswap;

   logic w_sready;
   logic w_start_ok;
   logic w_accept;
   logic w_commit;
   logic w_done;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Store waits for the last pixel write to drain; frame_rdy is ignored on the swap-pulse cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_sready    = 1'b0;
      w_start_ok  = 1'b0;
      w_commit    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_ok  = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_sready = 1'b1;
            if (s_valid && r_phase && (r_col == COL_LAST)) w_state_nxt = S_STORE_WAIT;
         end
         S_STORE_WAIT: begin
            if (fbw_row_rdy && !r_wren) begin
               w_commit    = 1'b1;
               w_state_nxt = (r_row == ROW_LAST) ? S_FRAME_SWAP : S_LOAD;
            end
         end
         S_FRAME_SWAP: w_state_nxt = S_FRAME_WAIT;
         S_FRAME_WAIT: begin
            if (frame_rdy && !r_fswap) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = w_sready & s_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= 1'b0;
         r_phase    <= 1'b0;
         r_lo       <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_wren     <= 1'b0;
         r_data     <= '0;
         r_col_addr <= '0;
         r_store    <= 1'b0;
         r_row_addr <= '0;
         r_fswap    <= 1'b0;
      end else begin
         r_wren  <= 1'b0;
         r_store <= 1'b0;
         r_fswap <= 1'b0;
         if (w_start_ok) begin
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_phase <= 1'b0;
         end
         if (w_done) r_busy <= 1'b0;
         if (w_accept) begin
            if (!r_phase) begin
               r_lo    <= s_data;
               r_phase <= 1'b1;
            end else begin
               r_phase    <= 1'b0;
               r_wren     <= 1'b1;
               r_data     <= {s_data, r_lo};
               r_col_addr <= r_col;
               r_col      <= r_col + 1'b1;
            end
         end
         // Row counter saturates at the last row; the next start rewinds it.
         if (w_commit) begin
            r_store    <= 1'b1;
            r_row_addr <= r_row;
            r_col      <= '0;
            if (r_row != ROW_LAST) r_row <= r_row + 1'b1;
         end
         if (r_state == S_FRAME_SWAP) r_fswap <= 1'b1;
      end
   end

   assign busy          = r_busy;
   assign done          = w_done;
   assign s_ready       = w_sready;
   assign fbw_wren      = r_wren;
   assign fbw_data      = r_data;
   assign fbw_col_addr  = r_col_addr;
   assign fbw_row_store = r_store;
   assign fbw_row_swap  = r_store;
   assign fbw_row_addr  = r_row_addr;
   assign frame_swap    = r_fswap;

endmodule

// File: tb/tb_fbw_stream_loader.sv
// Randomized and directed bench for fbw_stream_loader (2 rows x 4 columns) with a
// byte/row/frame counting reference model checked every cycle.
module tb_fbw_stream_loader;

   localparam int NR  = 2;
   localparam int NC  = 4;
   localparam int LR  = $clog2(NR);
   localparam int LC  = $clog2(NC);
   localparam int FRB = NR * NC * 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_ready;
   logic [LR-1:0] fbw_row_addr;
   logic          fbw_row_store;
   logic          fbw_row_rdy;
   logic          fbw_row_swap;
   logic [15:0]   fbw_data;
   logic [LC-1:0] fbw_col_addr;
   logic          fbw_wren;
   logic          frame_swap;
   logic          frame_rdy;

   fbw_stream_loader #(.N_ROWS(NR), .N_COLS(NC), .BITDEPTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
      .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr),
      .fbw_wren(fbw_wren), .frame_swap(frame_swap), .frame_rdy(frame_rdy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // stimulus controls: vmode 0=always 1=toggle 2=off 3=random; rmode 0=high 1=low 2=random
   int         vmode = 0;
   int         rmode = 0;
   bit         tog = 1'b0;
   logic [7:0] src_q[$];
   logic [7:0] exp_q[$];
   logic [15:0] wlog_d[$];
   int         wlog_c[$];
   int         hs_cnt = 0;
   int         done_cnt = 0;
   int         fswap_cnt = 0;
   int         store_cnt = 0;
   int         fs_age = 1000;

   // reference model: progress measured in bytes consumed and rows committed
   bit          m_init = 1'b0;
   bit          m_busy, m_wren, m_store, m_fswap, m_wait;
   int          m_bytes, m_rows, m_col, m_raddr, m_stage;
   logic [7:0]  m_lo;
   logic [15:0] m_data;
   bit          e_sready, e_done, row_full, hs, nw, ns, nf;

   always @(negedge clk) begin
      row_full = m_busy && (m_rows < NR) && (m_bytes == 2 * NC * (m_rows + 1));
      e_sready = m_busy && (m_rows < NR) && !row_full;
      e_done   = m_wait && frame_rdy;
      if (m_init) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("s_ready", 32'(s_ready), 32'(e_sready));
         chk("wren", 32'(fbw_wren), 32'(m_wren));
         if (m_wren) begin
            chk("data", 32'(fbw_data), 32'(m_data));
            chk("col", 32'(fbw_col_addr), 32'(m_col));
         end
         chk("row_store", 32'(fbw_row_store), 32'(m_store));
         chk("row_swap", 32'(fbw_row_swap), 32'(m_store));
         chk("row_addr", 32'(fbw_row_addr), 32'(m_raddr));
         chk("frame_swap", 32'(frame_swap), 32'(m_fswap));
         chk("done", 32'(done), 32'(e_done));
      end
      if (s_valid && s_ready && src_q.size() > 0) begin
         void'(src_q.pop_front());
         hs_cnt++;
      end
      if (fbw_wren) begin
         wlog_d.push_back(fbw_data);
         wlog_c.push_back(int'(fbw_col_addr));
      end
      if (fbw_row_store) store_cnt++;
      if (frame_swap) begin
         fswap_cnt++;
         fs_age = 0;
      end else if (fs_age < 1000) fs_age++;
      if (done) begin
         done_cnt++;
         fs_age = 1000;
      end
      if (rst) begin
         m_init = 1'b1; m_busy = 1'b0; m_wren = 1'b0; m_store = 1'b0; m_fswap = 1'b0;
         m_wait = 1'b0; m_bytes = 0; m_rows = 0; m_col = 0; m_raddr = 0; m_stage = 0;
         m_lo = 8'h00; m_data = 16'h0000;
      end else if (m_init) begin
         hs = s_valid && e_sready;
         nw = 1'b0; ns = 1'b0; nf = 1'b0;
         if (hs) begin
            if (m_bytes % 2 == 0) m_lo = s_data;
            else begin
               nw     = 1'b1;
               m_data = {s_data, m_lo};
               m_col  = (m_bytes / 2) % NC;
            end
            m_bytes++;
         end
         if (row_full && !m_wren && fbw_row_rdy) begin
            ns      = 1'b1;
            m_raddr = m_rows;
            m_rows++;
            if (m_rows == NR) m_stage = 1;
         end else if (m_stage == 1) begin
            nf      = 1'b1;
            m_stage = 2;
         end else if (m_stage == 2) begin
            m_wait  = 1'b1;
            m_stage = 0;
         end
         if (!m_busy && start) begin
            m_busy  = 1'b1;
            m_bytes = 0;
            m_rows  = 0;
         end
         if (e_done) begin
            m_busy = 1'b0;
            m_wait = 1'b0;
         end
         m_wren  = nw;
         m_store = ns;
         m_fswap = nf;
      end
   end

   task automatic cyc();
      bit vv;
      @(posedge clk);
      #1;
      case (vmode)
         0: vv = 1'b1;
         1: begin tog = !tog; vv = tog; end
         2: vv = 1'b0;
         default: vv = 1'($urandom_range(0, 1));
      endcase
      s_valid     = vv && (src_q.size() > 0);
      s_data      = (src_q.size() > 0) ? src_q[0] : 8'h00;
      fbw_row_rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      frame_rdy   = (fs_age >= 5) && (fs_age < 1000);
   endtask

   task automatic load_seq(input int extra);
      src_q.delete();
      for (int i = 0; i < FRB + extra; i++) src_q.push_back(8'(i + 1));
      exp_q = src_q;
   endtask

   task automatic load_rand();
      src_q.delete();
      for (int i = 0; i < FRB; i++) src_q.push_back(8'($urandom_range(0, 255)));
      exp_q = src_q;
   endtask

   task automatic chk_pixels();
      chk("npix", 32'(wlog_d.size()), 32'(NR * NC));
      for (int k = 0; k < wlog_d.size() && k < NR * NC; k++) begin
         chk("pix", 32'(wlog_d[k]), 32'({exp_q[2*k+1], exp_q[2*k]}));
         chk("pcol", 32'(wlog_c[k]), 32'(k % NC));
      end
   endtask

   task automatic run_frame(input bit s5, input bit hold, input bit gap, input int abort_at);
      int dstart;
      int held;
      int gc;
      int f0;
      wlog_d.delete();
      wlog_c.delete();
      hs_cnt = 0;
      dstart = done_cnt;
      f0     = fswap_cnt;
      held   = 0;
      gc     = 0;
      start  = 1'b1;
      cyc();
      start  = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done_cnt != dstart) break;
         if (abort_at > 0 && hs_cnt >= abort_at) begin
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            src_q.delete();
            repeat (4) cyc();
            chk("abort_no_fswap", 32'(fswap_cnt - f0), 32'd0);
            chk("abort_no_done", 32'(done_cnt - dstart), 32'd0);
            return;
         end
         start = s5 && ((hs_cnt == 3) || (fs_age == 1));
         if (hold && hs_cnt >= 2 * NC) begin
            if (held < 20) held++;
            else rmode = 0;
         end
         if (gap && hs_cnt >= 1 && gc < 10) begin
            vmode = 2;
            gc++;
         end else if (gap) vmode = 1;
         cyc();
      end
      start = 1'b0;
      repeat (6) cyc();
      chk("done_count", 32'(done_cnt - dstart), 32'd1);
      chk("fswap_count", 32'(fswap_cnt - f0), 32'd1);
      chk("bytes", 32'(hs_cnt), 32'(FRB));
      chk_pixels();
   endtask

   initial begin
      int st0;
      // reset held with start and s_valid active
      rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
      fbw_row_rdy = 1'b1; frame_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sready", 32'(s_ready), 32'd0);
      chk("rst_wren", 32'(fbw_wren), 32'd0);
      chk("rst_store", 32'(fbw_row_store), 32'd0);
      chk("rst_fswap", 32'(frame_swap), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      cyc();

      // sequential bytes, back-to-back, with two excess bytes
      vmode = 0; rmode = 0;
      load_seq(2);
      st0 = store_cnt;
      run_frame(1'b0, 1'b0, 1'b0, 0);
      chk("lit0", 32'(wlog_d[0]), 32'h0201);
      chk("lit3", 32'(wlog_d[3]), 32'h0807);
      chk("lit4", 32'(wlog_d[4]), 32'h0A09);
      chk("lit7", 32'(wlog_d[7]), 32'h100F);
      chk("litcol5", 32'(wlog_c[5]), 32'd1);
      chk("stores", 32'(store_cnt - st0), 32'd2);
      chk("excess_left", 32'(src_q.size()), 32'd2);

      // row ready held low after row 0
      load_seq(0); rmode = 1;
      run_frame(1'b0, 1'b1, 1'b0, 0);
      chk("lit4_hold", 32'(wlog_d[4]), 32'h0A09);

      // toggling valid with a long gap inside the first pixel
      load_seq(0); rmode = 0; vmode = 1;
      run_frame(1'b0, 1'b0, 1'b1, 0);
      chk("lit0_gap", 32'(wlog_d[0]), 32'h0201);
      vmode = 0;

      // stray start pulses during load and frame wait
      load_seq(0);
      run_frame(1'b1, 1'b0, 1'b0, 0);

      // reset after three pixels of row 1, then a clean reload
      load_seq(0);
      run_frame(1'b0, 1'b0, 1'b0, 2 * NC + 6);
      load_seq(0);
      run_frame(1'b0, 1'b0, 1'b0, 0);
      chk("lit0_reload", 32'(wlog_d[0]), 32'h0201);
      chk("litcol0_reload", 32'(wlog_c[0]), 32'd0);

      // randomized data, valid and row-ready
      vmode = 3; rmode = 2;
      for (int f = 0; f < 3; f++) begin
         load_rand();
         run_frame(1'(f == 1), 1'b0, 1'b0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
